counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Programmable timer controller wrapped around a free-running up-counter datapath.
//  - Sequences start/stop/pause of the count.
//  - Divides the clock through a prescaler.
//  - Compares against a programmed period and raises terminal-count events.
//  - Supports one-shot and periodic modes.
//  - Sits between the control/register interface and any logic needing timed ticks.
// PARAMETERS
//  WIDTH    4  width of count and period
//  PRESC_W  4  width of prescale divider setting
// PORTS
//  clk       in   1        clock, rising edge
//  reset     in   1        asynchronous, active-high reset
//  start     in   1        1-cycle pulse: latch config, clear count, enter RUN
//  stop      in   1        1-cycle pulse: abort to IDLE
//  pause     in   1        level: freeze count while high (RUN<->HOLD)
//  mode      in   1        0 = one-shot, 1 = periodic; sampled at start
//  period    in   WIDTH    terminal count value; sampled at start
//  prescale  in   PRESC_W  enable every prescale+1 clocks; sampled at start
//  count     out  WIDTH    current count
//  tick      out  1        1-cycle pulse on terminal count
//  busy      out  1        high in RUN or HOLD
//  done      out  1        high in DONE (one-shot finished)
//  state     out  2        IDLE=00, RUN=01, HOLD=10, DONE=11
// BEHAVIOUR
//  - Reset (async): state=IDLE, count=0, tick=0, busy=0, done=0, prescaler=0,
//    latched config=0.
//  - All outputs are registered. busy/done decode the registered state.
//  - Priority each edge: stop > start > pause.
//    - stop in any state -> IDLE; count=0, prescaler=0.
//    - start in any state (incl. RUN/HOLD/DONE) -> RUN.
//      - Latches mode/period/prescale; count=0, prescaler=0.
//      - Restart is immediate; tick is not raised.
//  - Count enable (en):
//    - In RUN, prescaler counts 0..prescale_q.
//    - en=1 on the edge where prescaler==prescale_q; prescaler then wraps to 0.
//    - prescale_q=0 -> en every cycle.
//  - RUN, en=1, count!=period_q: count <= count+1.
//  - RUN, en=1, count==period_q:
//    - tick <= 1 (for exactly one cycle).
//    - periodic: count <= 0, stay RUN.
//    - one-shot: count holds period_q, state -> DONE.
//  - Tick spacing is (period_q+1)*(prescale_q+1) clocks.
//    - period_q=0: tick on every en, count stays 0.
//  - RUN with pause=1 -> HOLD. HOLD with pause=0 -> RUN.
//    - count and prescaler are frozen in HOLD and resume exactly where they stopped.
//  - start while pause=1 -> RUN; HOLD is entered on the next edge if pause is still high.
//  - DONE holds count=period_q and done=1 until start or stop.
//  - pause and en are ignored in IDLE and DONE. count only ever changes in RUN.
//  - No arithmetic overflow: count never exceeds period_q (max 2^WIDTH-1).
//    - Wrap to 0 is explicit.
//  - Config inputs changing while busy have no effect until the next start.
// TESTING
//  1. reset high mid-RUN (count=5) -> same cycle count=0, state=00, busy=0, tick=0.
//  2. periodic, period=3, prescale=0, start @edge0:
//     -> count 1,2,3 at edges 1-3.
//     -> edge4: count=0, tick=1 for one cycle.
//     -> tick repeats every 4 clocks.
//  3. one-shot, period=2, prescale=2, start:
//     -> count increments every 3 clocks.
//     -> tick once when count reaches 2.
//     -> state=11, done=1, count holds 2.
//  4. periodic, period=7, pause high after count=4 for 5 clocks:
//     -> state=10, count stays 4.
//     -> after pause low, RUN resumes 5,6,7,0 with tick at 0.
//  5. start and stop in same cycle while RUN -> IDLE, count=0.
//     start alone while RUN (count=3) -> count=0, no tick, new period latched.
//  6. period=0, prescale=1, periodic -> count stays 0, tick every 2 clocks.
//     period=15 (WIDTH=4) -> count 0..15, wraps, tick at wrap.

Source files
------------

// File: rtl/counter_sequencer.sv
// Programmable timer: start/stop/pause sequencing around a prescaled up-counter
// with one-shot and periodic terminal-count events.
module counter_sequencer #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               mode,
    input  logic [WIDTH-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    output logic [WIDTH-1:0]   count,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t             st;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] prescale_q;
    logic [WIDTH-1:0]   period_q;
    logic               mode_q;
    logic               en;

    assign en = (presc_cnt == prescale_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            count      <= '0;
            tick       <= 1'b0;
            presc_cnt  <= '0;
            prescale_q <= '0;
            period_q   <= '0;
            mode_q     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (stop) begin
                st        <= IDLE;
                count     <= '0;
                presc_cnt <= '0;
            end else if (start) begin
                st         <= RUN;
                count      <= '0;
                presc_cnt  <= '0;
                mode_q     <= mode;
                period_q   <= period;
                prescale_q <= prescale;
            end else begin
                unique case (st)
                    RUN: begin
                        if (pause) begin
                            st <= HOLD;
                        end else if (en) begin
                            presc_cnt <= '0;
                            if (count != period_q) begin
                                count <= count + 1'b1;
                            end else begin
                                // terminal count: periodic wraps, one-shot parks at period
                                tick <= 1'b1;
                                if (mode_q) count <= '0;
                                else        st    <= DONE;
                            end
                        end else begin
                            presc_cnt <= presc_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!pause) st <= RUN;
                    end
                    IDLE, DONE: ;
                endcase
            end
        end
    end

    assign state = st;
    assign busy  = (st == RUN) || (st == HOLD);
    assign done  = (st == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed literal checks plus random stimulus
// compared every cycle against an elapsed-run-clock model.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] period = '0;
    logic [3:0] prescale = '0;
    logic [3:0] count;
    logic       tick;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    counter_sequencer #(.WIDTH(4), .PRESC_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .count    (count),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase (0 idle,1 run,2 hold,3 done) and the number of clocks
    // spent advancing in RUN since the last start; outputs follow by arithmetic.
    int m_ph, m_r, m_per, m_ps;
    bit m_mode, m_adv;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph <= 0; m_r <= 0; m_per <= 0; m_ps <= 0;
            m_mode <= 0; m_adv <= 0;
        end else begin
            m_adv <= 0;
            if (stop) begin
                m_ph <= 0; m_r <= 0;
            end else if (start) begin
                m_ph <= 1; m_r <= 0;
                m_mode <= mode;
                m_per <= int'(period);
                m_ps <= int'(prescale);
            end else if (m_ph == 1 && pause) begin
                m_ph <= 2;
            end else if (m_ph == 2 && !pause) begin
                m_ph <= 1;
            end else if (m_ph == 1) begin
                m_r <= m_r + 1;
                m_adv <= 1;
                if (!m_mode && (m_r + 1) / (m_ps + 1) == m_per + 1) m_ph <= 3;
            end
        end
    end

    function automatic int exp_count();
        int ens = m_r / (m_ps + 1);
        if (m_mode) return ens % (m_per + 1);
        return (ens > m_per) ? m_per : ens;
    endfunction

    function automatic int exp_tick();
        int ens = m_r / (m_ps + 1);
        if (!m_adv || (m_r % (m_ps + 1)) != 0) return 0;
        if (m_mode) return int'((ens % (m_per + 1)) == 0);
        return int'(ens == m_per + 1);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("m_state", int'(state), m_ph);
            check("m_count", int'(count), exp_count());
            check("m_tick", int'(tick), exp_tick());
            check("m_busy", int'(busy), int'(m_ph == 1 || m_ph == 2));
            check("m_done", int'(done), int'(m_ph == 3));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input bit m, input int p, input int ps);
        start = 1'b1;
        mode = m;
        period = 4'(p);
        prescale = 4'(ps);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        wait_n(2);
        reset = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_state", int'(state), 0);
        check("rst_busy", int'(busy), 0);

        do_start(1, 3, 0);
        check("p3_c0", int'(count), 0);
        wait_n(1); check("p3_c1", int'(count), 1);
        wait_n(1); check("p3_c2", int'(count), 2);
        wait_n(1); check("p3_c3", int'(count), 3);
        wait_n(1); check("p3_wrap", int'(count), 0); check("p3_tick", int'(tick), 1);
        wait_n(1); check("p3_tick_off", int'(tick), 0); check("p3_c1b", int'(count), 1);
        wait_n(3); check("p3_tick2", int'(tick), 1);
        stop = 1'b1; wait_n(1); stop = 1'b0;
        check("stop_state", int'(state), 0);

        do_start(0, 2, 2);
        wait_n(8); check("os_c2", int'(count), 2); check("os_run", int'(state), 1);
        wait_n(1); check("os_tick", int'(tick), 1); check("os_done", int'(done), 1);
        check("os_state", int'(state), 3);
        wait_n(3); check("os_hold", int'(count), 2); check("os_tick_off", int'(tick), 0);

        do_start(1, 7, 0);
        wait_n(4); check("pz_c4", int'(count), 4);
        pause = 1'b1; wait_n(5);
        check("pz_hold", int'(state), 2); check("pz_frozen", int'(count), 4);
        pause = 1'b0; wait_n(1);
        check("pz_resume", int'(state), 1); check("pz_c4b", int'(count), 4);
        wait_n(3); check("pz_c7", int'(count), 7);
        wait_n(1); check("pz_wrap", int'(count), 0); check("pz_tick", int'(tick), 1);

        wait_n(2);
        start = 1'b1; stop = 1'b1; wait_n(1); start = 1'b0; stop = 1'b0;
        check("ss_state", int'(state), 0); check("ss_count", int'(count), 0);
        do_start(1, 9, 0);
        wait_n(3); check("rs_c3", int'(count), 3);
        do_start(1, 5, 0);
        check("rs_c0", int'(count), 0); check("rs_notick", int'(tick), 0);
        wait_n(5); check("rs_c5", int'(count), 5);
        wait_n(1); check("rs_newper", int'(count), 0); check("rs_tick", int'(tick), 1);

        do_start(1, 0, 1);
        wait_n(1); check("z_t0", int'(tick), 0);
        wait_n(1); check("z_t1", int'(tick), 1); check("z_c", int'(count), 0);
        wait_n(1); check("z_t2", int'(tick), 0);
        wait_n(1); check("z_t3", int'(tick), 1);
        do_start(1, 15, 0);
        wait_n(15); check("f_c15", int'(count), 15);
        wait_n(1); check("f_wrap", int'(count), 0); check("f_tick", int'(tick), 1);

        pause = 1'b1;
        do_start(1, 4, 0);
        check("sp_run", int'(state), 1);
        wait_n(1); check("sp_hold", int'(state), 2);
        pause = 1'b0;

        do_start(1, 9, 0);
        wait_n(5); check("ar_c5", int'(count), 5);
        #1 reset = 1'b1;
        #1;
        check("ar_count", int'(count), 0);
        check("ar_state", int'(state), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_tick", int'(tick), 0);
        @(negedge clk);
        reset = 1'b0;

        repeat (3000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 9) == 0);
            stop = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) pause = ~pause;
            mode = 1'($urandom);
            period = 4'($urandom);
            prescale = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        wait_n(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
